// File: rtl/ddr3_refresh_arbiter.sv
// ddr3_refresh_arbiter
// Command-slot scheduler between the user command port and the DDR3
// controller command input. It tracks owed AUTO REFRESH commands and slots
// them between user reads and writes. A refresh is issued when the user port
// is idle, or it is forced when the debt reaches its limit. After every
// refresh, all commands are held off for tRFC.
//
// Build option: DDR3_REF_POSTPONE_EN
//   defined   -> up to MAX_POSTPONE refreshes may be owed behind user traffic
//   undefined -> debt limit is 1, so every tick makes the refresh urgent
//
// Encoding of cmd_type: 01 read, 10 write, 11 refresh, 00 idle.

module ddr3_refresh_arbiter #(
    parameter int CLK_PERIOD   = 6,
    parameter int TREFI_NS     = 7800,
    parameter int TRFC_NS      = 160,
    parameter int MAX_POSTPONE = 8,
    parameter int ADDR_W       = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              user_valid,
    output logic              user_ready,
    input  logic              user_write,
    input  logic [ADDR_W-1:0] user_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [3:0]        ref_debt,
    output logic              ref_urgent,
    output logic              ref_overflow
);

    // Refresh timing expressed in UI clock cycles.
    localparam int TREFI_CYC = TREFI_NS / CLK_PERIOD;
    localparam int TRFC_CYC  = (TRFC_NS + CLK_PERIOD - 1) / CLK_PERIOD;

`ifdef DDR3_REF_POSTPONE_EN
    localparam int LIMIT = MAX_POSTPONE;
`else
    localparam int LIMIT = 1;
`endif

    localparam int         IW      = $clog2(TREFI_CYC + 1);
    localparam int         RW      = $clog2(TRFC_CYC + 1);
    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    // Reject configurations that the 4-bit debt counter cannot represent.
    if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_max_postpone
        $error("MAX_POSTPONE must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_USER,
        ST_REF,
        ST_WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     intv_cnt;
    logic [RW-1:0]     rfc_cnt;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic              tick;
    logic              ref_hs;
    logic              user_hs;

    assign tick       = init_done && (intv_cnt == IW'(TREFI_CYC - 1));
    assign ref_hs     = cmd_valid && cmd_ready && (cmd_type == CMD_REF);
    assign user_hs    = user_valid && user_ready;
    assign ref_urgent = (ref_debt == LIMIT_V);

    // The tREFI interval counter runs only once init is done, and it wraps with a one-cycle tick.
    // NOTE: state registers use non-blocking assignments. This way, every
    // always_ff block reads values from before the clock edge, whatever the
    // order in which the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            intv_cnt <= '0;
        end else if (tick) begin
            intv_cnt <= '0;
        end else begin
            intv_cnt <= intv_cnt + 1'b1;
        end
    end

    // Refresh debt: a tick adds one and a refresh handshake removes one. A tick at the limit sets the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_debt     <= '0;
            ref_overflow <= 1'b0;
        end else if (tick && !ref_hs) begin
            if (ref_debt == LIMIT_V) begin
                ref_overflow <= 1'b1;
            end else begin
                ref_debt <= ref_debt + 4'd1;
            end
        end else if (!tick && ref_hs) begin
            ref_debt <= ref_debt - 4'd1;
        end
    end

    // State register, captured user request and tRFC hold-off counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rfc_cnt   <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (user_hs) begin
                cap_write <= user_write;
                cap_addr  <= user_addr;
            end
            if (ref_hs) begin
                rfc_cnt <= RW'(TRFC_CYC - 1);
            end else if (state == ST_WAIT && rfc_cnt != '0) begin
                rfc_cnt <= rfc_cnt - 1'b1;
            end
        end
    end

    // Next-state logic and command outputs. In IDLE the priority is: urgent refresh, then user request, then opportunistic refresh.
    // NOTE: every output of this block gets a default first. This way, no path
    // leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        user_ready = 1'b0;
        cmd_valid  = 1'b0;
        cmd_type   = CMD_IDLE;
        cmd_addr   = '0;
        case (state)
            ST_IDLE: begin
                user_ready = init_done && !ref_urgent;
                if (init_done) begin
                    if (ref_urgent) begin
                        state_nxt = ST_REF;
                    end else if (user_valid) begin
                        state_nxt = ST_USER;
                    end else if (ref_debt != 4'd0) begin
                        state_nxt = ST_REF;
                    end
                end
            end
            ST_USER: begin
                cmd_valid = 1'b1;
                cmd_type  = cap_write ? CMD_WRITE : CMD_READ;
                cmd_addr  = cap_addr;
                if (cmd_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REF: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_REF;
                if (cmd_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rfc_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ddr3_refresh_arbiter.md
# ddr3_refresh_arbiter

Command-slot scheduler between the user command port and the DDR3 controller's command input. Counts tREFI and accumulates owed AUTO REFRESH commands, with up to MAX_POSTPONE owed. Interleaves those refreshes with user read/write requests: opportunistically when the user port is idle, forcibly when the debt limit is reached. Blocks all commands for tRFC after each refresh. Runs entirely in the UI clock domain (CLK_PERIOD = 2 × DDR clock period).

## Interface
- CLK_PERIOD, 6: UI clock period in ns.
- TREFI_NS, 7800: average refresh interval in ns.
- TRFC_NS, 160: refresh-to-command time in ns.
- MAX_POSTPONE, 8: maximum owed refreshes (1..15).
- ADDR_W, 28: user address width.

Ports:
- clk  in  1  UI clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- init_done  in  1  controller power-up init complete.
- user_valid  in  1  user request valid.
- user_ready  out  1  request accepted when valid & ready.
- user_write  in  1  1 = write, 0 = read.
- user_addr  in  ADDR_W  request address.
- cmd_valid  out  1  command to controller valid.
- cmd_ready  in  1  controller accepts command.
- cmd_type  out  2  01 read, 10 write, 11 refresh, 00 idle.
- cmd_addr  out  ADDR_W  command address (0 for refresh).
- ref_debt  out  4  owed refresh count.
- ref_urgent  out  1  ref_debt == effective limit.
- ref_overflow  out  1  sticky: tick occurred while debt at limit.

## Operation
- Derived constants:
  - TREFI_CYC = floor(TREFI_NS / CLK_PERIOD), giving 1300 at defaults.
  - TRFC_CYC = ceil(TRFC_NS / CLK_PERIOD), giving 27 at defaults.
  - All are integer elaboration-time values.
- Interval counter:
  - Held at 0 while init_done = 0.
  - Otherwise counts 0..TREFI_CYC-1 and wraps.
  - Wrap produces a one-cycle tick.
- Debt tracking:
  - Tick increments ref_debt.
  - A refresh handshake (cmd_valid & cmd_ready & cmd_type = 11) decrements ref_debt.
  - Tick and handshake in the same cycle leave ref_debt unchanged.
  - Tick at the limit without a simultaneous handshake keeps ref_debt saturated and sets ref_overflow. Only reset clears ref_overflow.
- States:
  - IDLE
    - init_done = 0: user_ready = 0.
    - ref_urgent: user_ready = 0, go to REF.
    - user_valid: user_ready = 1, capture write/addr, go to USER.
    - ref_debt > 0 and no user_valid: go to REF.
  - USER: cmd_valid = 1, cmd_type = 01 or 10, cmd_addr = captured address. On cmd_ready, go to IDLE.
  - REF: cmd_valid = 1, cmd_type = 11, cmd_addr = 0. On cmd_ready, go to WAIT and load the tRFC counter with TRFC_CYC-1.
  - WAIT: cmd_valid = 0, user_ready = 0. Counter decrements each cycle; at 0, go to IDLE.
- Handshake rules:
  - cmd_type and cmd_addr stay stable while cmd_valid & !cmd_ready.
  - cmd_valid never drops without a handshake, except on reset.
  - user_ready is combinational from state, ref_urgent and init_done only. It has no dependence on cmd_ready.
- Priority in IDLE: urgent refresh > user request > opportunistic refresh.

## Timing
- Reset values (reset sampled high at a clk edge clears everything next cycle, including mid-command):
  - state IDLE, both counters 0, ref_debt 0.
  - cmd_valid 0, cmd_type 00, cmd_addr 0.
  - ref_urgent 0, ref_overflow 0.
- Latency: user handshake at edge N gives cmd_valid = 1 in cycle N+1. One user command is in flight at most.
- Refresh spacing:
  - After a refresh handshake at edge N, no cmd_valid before cycle N+TRFC_CYC+1.
  - IDLE may issue the next command in cycle N+TRFC_CYC+1.
- First tick occurs TREFI_CYC cycles after the first cycle with init_done = 1.
- init_done falling mid-operation:
  - Counter clears; debt is kept.
  - In-flight commands complete normally.

## Configuration
- DDR3_REF_POSTPONE_EN
  - Defined: effective limit = MAX_POSTPONE. Refreshes may be deferred behind user traffic until the limit is reached.
  - Undefined: effective limit = 1. Every tick makes ref_urgent = 1 immediately, so a refresh preempts the next IDLE decision. MAX_POSTPONE is ignored and ref_debt never exceeds 1.

## Test plan
- Setup for all scenarios: defaults, init_done = 1 after reset, cmd_ready = 1.
- Idle port: ticks at cycles 1300, 2600 → refresh command in cycle 1301, then in 2601; ref_debt returns to 0; gap ≥ 27 cycles.
- Continuous user_valid, POSTPONE enabled:
  - user commands only until ref_debt = 8 (tick 8, cycle 10400);
  - then user_ready = 0 and ref_urgent = 1;
  - one refresh, 27 WAIT cycles, then user traffic resumes.
- Backpressure: hold cmd_ready = 0 for 5 cycles during a USER write to addr 0x0ABCDEF → cmd_type = 10 and cmd_addr stable for all 5 cycles; exactly one handshake.
- Overflow:
  - Setup: cmd_ready = 0 indefinitely with debt at 8.
  - Next tick → ref_overflow = 1 and ref_debt stays 8.
  - Reset → all zero.
- Reset during WAIT (10 cycles into tRFC) → next cycle IDLE, cmd_valid = 0, ref_debt = 0.
- Macro undefined with continuous user_valid → refresh issued within 2 cycles after each tick; ref_debt ≤ 1 throughout.
